// File: rtl/conv1_pkg.sv
// Shared widths, pixel/window types and FSM encoding for the conv1 window generator.
package conv1_pkg;

  localparam int unsigned DW    = 16;
  localparam int unsigned CH    = 3;
  localparam int unsigned TAPS  = 9;
  localparam int unsigned PIX_W = DW * CH;
  localparam int unsigned ACT_W = PIX_W * TAPS;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [ACT_W-1:0] act_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Bit offset of channel ch of tap k inside the flattened window.
  function automatic int unsigned act_offset(input int unsigned ch, input int unsigned k);
    return (ch * TAPS * DW) + (k * DW);
  endfunction

endpackage

// File: rtl/conv1_line_buf.sv
// One-row pixel delay: reading address a returns the pixel written there one row earlier.
module conv1_line_buf
  import conv1_pkg::*;
#(
  parameter int unsigned IMG_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en_i,
  input  logic restart_i,
  input  pix_t wr_data_i,
  output pix_t rd_data_c
);

  localparam int unsigned AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  pix_t          mem_q [IMG_W];
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;
  logic [AW-1:0] addr_c;

  // A restarting frame writes column 0 regardless of where the pointer was.
  always_comb begin
    addr_c = restart_i ? '0 : ptr_q;
    ptr_d  = ptr_q;
    if (wr_en_i) begin
      ptr_d = (addr_c == AW'(IMG_W - 1)) ? '0 : addr_c + AW'(1);
    end
  end

  assign rd_data_c = mem_q[addr_c];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage holds no reset; stale rows are never emitted.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[addr_c] <= wr_data_i;
    end
  end

endmodule

// File: rtl/conv1_window_gen.sv
// Streams 3x3x3 convolution windows out of a raster pixel stream.
// Optional build macro CONV1_WIN_STRIDE2_EN selects stride 2 (default stride 1).
module conv1_window_gen
  import conv1_pkg::*;
#(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             in_ready,
  output logic             valid,
  output logic [ACT_W-1:0] input_act,
  output logic             frame_done,
  output logic             sof_err
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

`ifdef CONV1_WIN_STRIDE2_EN
  localparam int unsigned LAST_WR = (IMG_H - 1) - ((IMG_H - 1) % 2);
  localparam int unsigned LAST_WC = (IMG_W - 1) - ((IMG_W - 1) % 2);
`else
  localparam int unsigned LAST_WR = IMG_H - 1;
  localparam int unsigned LAST_WC = IMG_W - 1;
`endif

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] col_q;
  logic [CW-1:0] col_d;
  logic [RW-1:0] row_q;
  logic [RW-1:0] row_d;
  logic          in_ready_q;
  logic          in_ready_d;
  logic          valid_q;
  logic          valid_d;
  logic          frame_done_q;
  logic          frame_done_d;
  logic          sof_err_q;
  logic          sof_err_d;
  act_t          act_q;
  act_t          act_d;
  pix_t          win_q [3][3];
  pix_t          win_d [3][3];

  logic          acc_c;
  logic          take_c;
  logic [CW-1:0] pcol_c;
  logic [RW-1:0] prow_c;
  logic          last_pix_c;
  logic          stride_ok_c;
  logic          emit_c;
  pix_t          lb0_rd_c;
  pix_t          lb1_rd_c;
  act_t          act_pack_c;

  assign in_ready   = in_ready_q;
  assign valid      = valid_q;
  assign frame_done = frame_done_q;
  assign sof_err    = sof_err_q;
  assign input_act  = act_q;

  // Pixels outside a frame are only taken when they open one.
  assign acc_c      = in_valid & in_ready_q;
  assign take_c     = acc_c & (in_sof | (state_q == ST_ACTIVE));
  assign pcol_c     = in_sof ? '0 : col_q;
  assign prow_c     = in_sof ? '0 : row_q;
  assign last_pix_c = (prow_c == RW'(IMG_H - 1)) && (pcol_c == CW'(IMG_W - 1));

`ifdef CONV1_WIN_STRIDE2_EN
  assign stride_ok_c = ~prow_c[0] & ~pcol_c[0];
`else
  assign stride_ok_c = 1'b1;
`endif

  assign emit_c = take_c && (prow_c >= RW'(2)) && (pcol_c >= CW'(2)) && stride_ok_c;

  // lb0 delays the input by one row, lb1 delays lb0 by one more.
  conv1_line_buf #(.IMG_W(IMG_W)) u_lb0 (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (take_c),
    .restart_i (in_sof),
    .wr_data_i (in_pixel),
    .rd_data_c (lb0_rd_c)
  );

  conv1_line_buf #(.IMG_W(IMG_W)) u_lb1 (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (take_c),
    .restart_i (in_sof),
    .wr_data_i (lb0_rd_c),
    .rd_data_c (lb1_rd_c)
  );

  // Window shifts left; the new right column is (row-2, row-1, row).
  always_comb begin
    win_d = win_q;
    if (take_c) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd_c;
      win_d[1][2] = lb0_rd_c;
      win_d[2][2] = in_pixel;
    end
  end

  always_comb begin
    act_pack_c = '0;
    for (int k = 0; k < int'(TAPS); k++) begin
      for (int ch = 0; ch < int'(CH); ch++) begin
        act_pack_c[act_offset(ch, k) +: DW] = win_d[k / 3][k % 3][ch * DW +: DW];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    valid_d      = 1'b0;
    frame_done_d = 1'b0;
    sof_err_d    = 1'b0;
    act_d        = act_q;
    in_ready_d   = 1'b1;
    case (state_q)
      ST_IDLE, ST_ACTIVE: begin
        if (take_c) begin
          sof_err_d = in_sof && (state_q == ST_ACTIVE);
          if (last_pix_c) begin
            state_d = ST_DONE;
            col_d   = '0;
            row_d   = '0;
          end else begin
            state_d = ST_ACTIVE;
            if (pcol_c == CW'(IMG_W - 1)) begin
              col_d = '0;
              row_d = prow_c + RW'(1);
            end else begin
              col_d = pcol_c + CW'(1);
              row_d = prow_c;
            end
          end
          if (emit_c) begin
            valid_d      = 1'b1;
            act_d        = act_pack_c;
            frame_done_d = (prow_c == RW'(LAST_WR)) && (pcol_c == CW'(LAST_WC));
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d = (state_d != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      in_ready_q   <= 1'b1;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
      act_q        <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      in_ready_q   <= in_ready_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
      act_q        <= act_d;
      win_q        <= win_d;
    end
  end

endmodule

// File: tb/tb_conv1_window_gen.sv
// Self-checking bench for conv1_window_gen: directed scenarios plus random streams
// checked against an image-array reference model.
module tb_conv1_window_gen;
  import conv1_pkg::*;

  localparam int W = 4;
  localparam int H = 4;
`ifdef CONV1_WIN_STRIDE2_EN
  localparam int EXP_WIN = 1;
`else
  localparam int EXP_WIN = 4;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_sof;
  logic [PIX_W-1:0]     in_pixel;
  logic                 in_ready;
  logic                 valid;
  logic [ACT_W-1:0]     input_act;
  logic                 frame_done;
  logic                 sof_err;

  conv1_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_pixel   (in_pixel),
    .in_ready   (in_ready),
    .valid      (valid),
    .input_act  (input_act),
    .frame_done (frame_done),
    .sof_err    (sof_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: current-frame image plus frame position bookkeeping.
  logic [PIX_W-1:0] img [H][W];
  bit               m_active;
  bit               m_ready;
  int               m_row;
  int               m_col;
  logic [ACT_W-1:0] m_act;
  int               last_wr;
  int               last_wc;
  int               vcount;
  int               fdcount;
  int               serrcount;
  bit               first_seen;
  logic [ACT_W-1:0] first_act;
  logic [15:0]      tap_val;

  task automatic chk(input string tag, input logic [ACT_W-1:0] obs, input logic [ACT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit emits(input int r, input int c);
`ifdef CONV1_WIN_STRIDE2_EN
    return (r >= 2) && (c >= 2) && ((r - 2) % 2 == 0) && ((c - 2) % 2 == 0);
`else
    return (r >= 2) && (c >= 2);
`endif
  endfunction

  function automatic logic [ACT_W-1:0] window(input int pr, input int pc);
    logic [ACT_W-1:0] a;
    logic [PIX_W-1:0] p;
    a = '0;
    for (int k = 0; k < 9; k++) begin
      p = img[pr - 2 + k / 3][pc - 2 + k % 3];
      for (int ch = 0; ch < 3; ch++) begin
        a[144 * ch + 16 * k +: 16] = p[16 * ch +: 16];
      end
    end
    return a;
  endfunction

  function automatic logic [PIX_W-1:0] ramp(input int r, input int c, input int base);
    int v;
    v = base + 16 * r + 4 * c;
    return {16'(v + 2), 16'(v + 1), 16'(v)};
  endfunction

  // One clock: drive inputs, predict, clock, check every output.
  task automatic step(input logic v, input logic s, input logic [PIX_W-1:0] p);
    bit take;
    bit ev;
    bit efd;
    bit es;
    bit fin;
    int pr;
    int pc;
    in_valid = v;
    in_sof   = s;
    in_pixel = p;
    chk("in_ready", 432'(in_ready), 432'(m_ready));
    take = v && m_ready && (s || m_active);
    ev = 1'b0; efd = 1'b0; es = 1'b0; fin = 1'b0;
    if (take) begin
      es = s && m_active;
      pr = s ? 0 : m_row;
      pc = s ? 0 : m_col;
      img[pr][pc] = p;
      if (emits(pr, pc)) begin
        ev    = 1'b1;
        m_act = window(pr, pc);
        efd   = (pr == last_wr) && (pc == last_wc);
      end
      fin = (pr == H - 1) && (pc == W - 1);
      if (fin) begin
        m_active = 1'b0;
        m_row = 0;
        m_col = 0;
      end else begin
        m_active = 1'b1;
        m_row = (pc == W - 1) ? pr + 1 : pr;
        m_col = (pc + 1) % W;
      end
    end
    m_ready = !fin;
    @(posedge clk);
    #1;
    chk("valid", 432'(valid), 432'(ev));
    chk("frame_done", 432'(frame_done), 432'(efd));
    chk("sof_err", 432'(sof_err), 432'(es));
    chk("input_act", input_act, m_act);
    if (valid === 1'b1) begin
      vcount++;
      if (!first_seen) begin
        first_seen = 1'b1;
        first_act  = input_act;
      end
    end
    if (frame_done === 1'b1) fdcount++;
    if (sof_err === 1'b1) serrcount++;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pixel = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_active = 1'b0;
    m_ready  = 1'b1;
    m_row    = 0;
    m_col    = 0;
    m_act    = '0;
    chk("rst_valid", 432'(valid), 432'(0));
    chk("rst_frame_done", 432'(frame_done), 432'(0));
    chk("rst_sof_err", 432'(sof_err), 432'(0));
    chk("rst_input_act", input_act, '0);
    chk("rst_in_ready", 432'(in_ready), 432'(1));
  endtask

  task automatic clear_counts();
    vcount = 0;
    fdcount = 0;
    serrcount = 0;
    first_seen = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit gapped);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        step(1'b1, (r == 0) && (c == 0), ramp(r, c, base));
        if (gapped) step(1'b0, 1'b0, {$urandom, $urandom});
      end
    end
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
  endtask

  initial begin
    last_wr = 0;
    last_wc = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (emits(r, c)) begin
          last_wr = r;
          last_wc = c;
        end

    do_reset();

    // Ramp frame with continuous in_valid.
    clear_counts();
    send_frame(0, 1'b0);
    chk("ramp_nvalid", 432'(vcount), 432'(EXP_WIN));
    chk("ramp_nframe_done", 432'(fdcount), 432'(1));
    tap_val = first_act[0 +: 16];
    chk("ramp_tap0_ch0", 432'(tap_val), 432'(0));
    tap_val = first_act[144 + 64 +: 16];
    chk("ramp_tap4_ch1", 432'(tap_val), 432'(21));
    tap_val = first_act[288 + 128 +: 16];
    chk("ramp_tap8_ch2", 432'(tap_val), 432'(42));

    // Same ramp with in_valid toggling.
    clear_counts();
    send_frame(0, 1'b1);
    chk("gap_nvalid", 432'(vcount), 432'(EXP_WIN));
    chk("gap_nframe_done", 432'(fdcount), 432'(1));

    // Mid-frame in_sof at (1,3).
    clear_counts();
    for (int i = 0; i < 7; i++) step(1'b1, i == 0, ramp(i / W, i % W, 500));
    send_frame(200, 1'b0);
    chk("sof_err_count", 432'(serrcount), 432'(1));
    chk("sof_nvalid", 432'(vcount), 432'(EXP_WIN));
    chk("sof_nframe_done", 432'(fdcount), 432'(1));

    // Reset right after pixel (2,2).
    clear_counts();
    for (int i = 0; i < 11; i++) step(1'b1, i == 0, ramp(i / W, i % W, 300));
    do_reset();
    clear_counts();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    chk("rst_mid_nframe_done", 432'(fdcount), 432'(0));
    chk("rst_mid_nvalid", 432'(vcount), 432'(0));
    send_frame(400, 1'b0);
    chk("post_rst_nvalid", 432'(vcount), 432'(EXP_WIN));

    // Pixels without in_sof while idle are dropped.
    clear_counts();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, {$urandom, $urandom});
    chk("presof_nvalid", 432'(vcount), 432'(0));
    send_frame(600, 1'b0);
    chk("presof_then_frame_nvalid", 432'(vcount), 432'(EXP_WIN));

    // Random streams with occasional in_sof and reset.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, {$urandom, $urandom});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
